// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate sequencer driving the 4-bit combinational shifter.
// Optional abort input is enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_sequencer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [3:0]       load_val,
    input  logic [CNT_W-1:0] count,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [3:0]       sh_i,
    output logic [1:0]       sh_sel,
    input  logic [3:0]       sh_d,
    output logic [3:0]       data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state_r;
    logic [3:0]       operand_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] remaining_r;
    logic [1:0]       sel_r;
    logic             busy_r;
    logic             done_r;
    logic             abort_s;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Sequencer FSM; sel/busy/done are registered alongside the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            operand_r   <= 4'b0000;
            mode_r      <= 2'b00;
            remaining_r <= {CNT_W{1'b0}};
            sel_r       <= 2'b00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sel_r  <= 2'b00;
                    done_r <= 1'b0;
                    if (start) begin
                        operand_r   <= load_val;
                        mode_r      <= mode;
                        remaining_r <= count;
                        state_r     <= LOAD;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort_s) begin
                        state_r     <= IDLE;
                        remaining_r <= {CNT_W{1'b0}};
                        sel_r       <= 2'b00;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end else if (remaining_r != {CNT_W{1'b0}}) begin
                        state_r <= RUN;
                        sel_r   <= mode_r;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= DONE;
                        sel_r   <= 2'b00;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort wins over the write-back so the operand freezes
                    if (abort_s) begin
                        state_r     <= IDLE;
                        remaining_r <= {CNT_W{1'b0}};
                        sel_r       <= 2'b00;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end else begin
                        operand_r   <= sh_d;
                        remaining_r <= remaining_r - CNT_W'(1);
                        if (remaining_r == CNT_W'(1)) begin
                            state_r <= DONE;
                            sel_r   <= 2'b00;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            sel_r   <= mode_r;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    sel_r   <= 2'b00;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    remaining_r <= {CNT_W{1'b0}};
                    sel_r       <= 2'b00;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign sh_i     = operand_r;
    assign data_out = operand_r;
    assign sh_sel   = sel_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with an attached shifter model.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [2:0] count;
    logic [3:0] sh_i;
    logic [1:0] sh_sel;
    logic [3:0] sh_d;
    logic [3:0] data_out;
    logic       busy;
    logic       done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       abort;
`endif

    int total;
    int bad;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] lv;
        logic [1:0] md;
        logic [2:0] cnt;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs[9];

    shift_sequencer #(.CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .load_val (load_val),
        .count    (count),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .sh_i     (sh_i),
        .sh_sel   (sh_sel),
        .sh_d     (sh_d),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-fill shifter sitting downstream of the sequencer
    always_comb begin
        case (sh_sel)
            2'b01:   sh_d = {sh_i[2:0], 1'b0};
            2'b10:   sh_d = {1'b0, sh_i[3:1]};
            2'b11:   sh_d = {sh_i[2:0], sh_i[3]};
            default: sh_d = sh_i;
        endcase
    end

    function automatic logic [3:0] ref_op(input logic [3:0] v, input logic [1:0] m, input int n);
        logic [3:0] r;
        r = v;
        for (int k = 0; k < n; k++) begin
            case (m)
                2'b01:   r = {r[2:0], 1'b0};
                2'b10:   r = {1'b0, r[3:1]};
                2'b11:   r = {r[2:0], r[3]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cmd(input logic [3:0] lv, input logic [1:0] md, input logic [2:0] cnt,
                           input logic [3:0] exp_d);
        int  cyc;
        bit  seen;
        logic [3:0] got;
        @(negedge clk);
        start = 1'b1; load_val = lv; mode = md; count = cnt;
        exp_q.push_back(exp_d);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("load_busy", {7'b0, busy}, 8'd1);
        check("load_sel", {6'b0, sh_sel}, 8'd0);
        check("load_data", {4'b0, data_out}, {4'b0, lv});
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else if (cyc <= int'(cnt)) begin
                check("run_busy", {7'b0, busy}, 8'd1);
                check("run_sel", {6'b0, sh_sel}, {6'b0, md});
                check("run_data", {4'b0, data_out}, {4'b0, ref_op(lv, md, cyc - 1)});
            end else begin
                check("late_done", {7'b0, done}, 8'd1);
            end
        end
        check("done_latency", 8'(cyc), 8'(int'(cnt) + 1));
        if (seen) begin
            got = exp_q.pop_front();
            check("final_data", {4'b0, data_out}, {4'b0, got});
            check("done_busy", {7'b0, busy}, 8'd0);
            check("done_sh_i", {4'b0, sh_i}, {4'b0, got});
            @(posedge clk);
            @(negedge clk);
            check("done_pulse_width", {7'b0, done}, 8'd0);
            check("held_data", {4'b0, data_out}, {4'b0, got});
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        bit saw_done;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        mode = 2'b00;
        load_val = 4'b0000;
        count = 3'd0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0] = '{4'b1001, 2'b01, 3'd1, 4'b0010};
        vecs[1] = '{4'b1111, 2'b10, 3'd2, 4'b0011};
        vecs[2] = '{4'b1001, 2'b11, 3'd1, 4'b0011};
        vecs[3] = '{4'b1011, 2'b11, 3'd4, 4'b1011};
        vecs[4] = '{4'b1011, 2'b10, 3'd0, 4'b1011};
        vecs[5] = '{4'b0110, 2'b00, 3'd3, 4'b0110};
        vecs[6] = '{4'b0001, 2'b01, 3'd7, 4'b0000};
        vecs[7] = '{4'b1000, 2'b10, 3'd3, 4'b0001};
        vecs[8] = '{4'b0011, 2'b11, 3'd2, 4'b1100};

        repeat (3) @(negedge clk);
        check("rst_data", {4'b0, data_out}, 8'd0);
        check("rst_sh_i", {4'b0, sh_i}, 8'd0);
        check("rst_sel", {6'b0, sh_sel}, 8'd0);
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_done", {7'b0, done}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_cmd(vecs[i].lv, vecs[i].md, vecs[i].cnt, vecs[i].exp_d);

        for (int i = 0; i < 6; i++) begin
            logic [3:0] rv;
            logic [1:0] rm;
            logic [2:0] rc;
            rv = 4'($urandom_range(0, 15));
            rm = 2'($urandom_range(0, 3));
            rc = 3'($urandom_range(0, 7));
            run_cmd(rv, rm, rc, ref_op(rv, rm, int'(rc)));
        end

        // start held high: later command values ignored while busy, accepted after one IDLE cycle
        @(negedge clk);
        start = 1'b1; load_val = 4'b0101; mode = 2'b01; count = 3'd3;
        @(posedge clk);
        @(negedge clk);
        load_val = 4'b1111; mode = 2'b10; count = 3'd1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("held_start_done", {7'b0, done}, 8'd1);
        check("held_start_data", {4'b0, data_out}, 8'h08);
        @(posedge clk);
        @(negedge clk);
        check("idle_gap_busy", {7'b0, busy}, 8'd0);
        check("idle_gap_data", {4'b0, data_out}, 8'h08);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("relaunch_busy", {7'b0, busy}, 8'd1);
        check("relaunch_data", {4'b0, data_out}, 8'h0f);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("relaunch_done", {7'b0, done}, 8'd1);
        check("relaunch_final", {4'b0, data_out}, 8'h07);

        // Reset in the second RUN cycle
        @(negedge clk);
        start = 1'b1; load_val = 4'b1111; mode = 2'b01; count = 3'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_data", {4'b0, data_out}, 8'h0e);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", {4'b0, data_out}, 8'd0);
        check("mid_rst_sel", {6'b0, sh_sel}, 8'd0);
        check("mid_rst_busy", {7'b0, busy}, 8'd0);
        check("mid_rst_done", {7'b0, done}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_rst", {7'b0, saw_done}, 8'd0);
        check("post_rst_busy", {7'b0, busy}, 8'd0);

`ifdef SHIFT_SEQ_ABORT_EN
        start = 1'b1; load_val = 4'b1111; mode = 2'b01; count = 3'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort_data", {4'b0, data_out}, 8'h0e);
        check("abort_busy", {7'b0, busy}, 8'd0);
        check("abort_done", {7'b0, done}, 8'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_abort", {7'b0, saw_done}, 8'd0);
        check("abort_held", {4'b0, data_out}, 8'h0e);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
